// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - ALU command FIFO with issue pacing and result tagging
// Optional build macro: ALU_ISSUE_DROP_INVALID_EN (discard packets with INP_VALID==2'b00)
module alu_issue_queue #(
  parameter int OPERAND_WIDTH = 8,
  parameter int CMD_WIDTH     = 4,
  parameter int DEPTH         = 4,
  parameter int TAG_WIDTH     = 4,
  parameter int ALU_LAT       = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic                       IN_MODE,
  input  logic [CMD_WIDTH-1:0]       IN_CMD,
  input  logic                       IN_CIN,
  input  logic [1:0]                 IN_INP_VALID,
  input  logic [OPERAND_WIDTH-1:0]   IN_OPA,
  input  logic [OPERAND_WIDTH-1:0]   IN_OPB,
  input  logic                       FLUSH,
  output logic                       ALU_CE,
  output logic                       ALU_MODE,
  output logic [CMD_WIDTH-1:0]       ALU_CMD,
  output logic                       ALU_CIN,
  output logic [1:0]                 ALU_INP_VALID,
  output logic [OPERAND_WIDTH-1:0]   ALU_OPA,
  output logic [OPERAND_WIDTH-1:0]   ALU_OPB,
  output logic                       RES_VLD,
  output logic [TAG_WIDTH-1:0]       RES_TAG,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       DROP
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                     mode;
    logic [CMD_WIDTH-1:0]     cmd;
    logic                     cin;
    logic [1:0]               inp_valid;
    logic [OPERAND_WIDTH-1:0] opa;
    logic [OPERAND_WIDTH-1:0] opb;
  } pkt_t;

  typedef enum logic {RUN, MUL_WAIT} state_t;

  pkt_t                 mem [DEPTH];
  pkt_t                 in_pkt;
  pkt_t                 head;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 ready_en;
  state_t               state;
  state_t               state_nxt;
  logic                 pop;
  logic                 head_mul;
  logic                 accept;
  logic                 drop_pkt;
  logic                 enq;
  logic [TAG_WIDTH-1:0] tag;
  logic [ALU_LAT:0]     vld_pipe;
  logic [TAG_WIDTH-1:0] tag_pipe [ALU_LAT+1];

  assign in_pkt   = '{mode: IN_MODE, cmd: IN_CMD, cin: IN_CIN, inp_valid: IN_INP_VALID,
                      opa: IN_OPA, opb: IN_OPB};
  assign head     = mem[rd_ptr];
  assign head_mul = head.mode && ((head.cmd == CMD_WIDTH'(9)) || (head.cmd == CMD_WIDTH'(10)));

  // ready_en keeps IN_READY low until the first edge after reset
  assign IN_READY = ready_en && (COUNT < CW'(DEPTH));
  assign accept   = IN_VALID && IN_READY;

`ifdef ALU_ISSUE_DROP_INVALID_EN
  assign drop_pkt = accept && !FLUSH && (IN_INP_VALID == 2'b00);
`else
  assign drop_pkt = 1'b0;
`endif

  assign enq = accept && !FLUSH && !drop_pkt;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      RUN: begin
        if (COUNT != '0) begin
          pop = 1'b1;
          if (head_mul) state_nxt = MUL_WAIT;
        end
      end
      MUL_WAIT: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
    if (FLUSH) begin
      pop       = 1'b0;
      state_nxt = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) state <= RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= in_pkt;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      COUNT    <= '0;
      ready_en <= 1'b0;
      DROP     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      DROP     <= drop_pkt;
      if (FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        COUNT  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({enq, pop})
          2'b10:   COUNT <= COUNT + 1'b1;
          2'b01:   COUNT <= COUNT - 1'b1;
          default: COUNT <= COUNT;
        endcase
      end
    end
  end

  // Operand/command outputs hold when idle; only CE and INP_VALID drop
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ALU_CE        <= 1'b0;
      ALU_MODE      <= 1'b0;
      ALU_CMD       <= '0;
      ALU_CIN       <= 1'b0;
      ALU_INP_VALID <= 2'b00;
      ALU_OPA       <= '0;
      ALU_OPB       <= '0;
      tag           <= '0;
    end else if (pop) begin
      ALU_CE        <= 1'b1;
      ALU_MODE      <= head.mode;
      ALU_CMD       <= head.cmd;
      ALU_CIN       <= head.cin;
      ALU_INP_VALID <= head.inp_valid;
      ALU_OPA       <= head.opa;
      ALU_OPB       <= head.opb;
      tag           <= tag + 1'b1;
    end else begin
      ALU_CE        <= 1'b0;
      ALU_INP_VALID <= 2'b00;
    end
  end

  // Slot k reaches RES_VLD k+1 edges later; multiplies enter one slot deeper
  always_ff @(posedge CLK) begin
    if (!RST) begin
      vld_pipe <= '0;
      for (int k = 0; k <= ALU_LAT; k++) tag_pipe[k] <= '0;
      RES_VLD  <= 1'b0;
      RES_TAG  <= '0;
    end else begin
      RES_VLD <= vld_pipe[0];
      RES_TAG <= tag_pipe[0];
      for (int k = 0; k < ALU_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k+1];
        tag_pipe[k] <= tag_pipe[k+1];
      end
      vld_pipe[ALU_LAT] <= 1'b0;
      if (pop) begin
        if (head_mul) begin
          vld_pipe[ALU_LAT] <= 1'b1;
          tag_pipe[ALU_LAT] <= tag;
        end else begin
          vld_pipe[ALU_LAT-1] <= 1'b1;
          tag_pipe[ALU_LAT-1] <= tag;
        end
      end
    end
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream stage of alu_design. Buffers ALU command packets from a producer in a small FIFO.
- Paces issue into the ALU: one op per cycle, plus one bubble after multiply commands.
- Tags every issued op and reports the tag when the matching ALU result is due, so downstream logic can pair RES/flags with the request.

Parameters:
OPERAND_WIDTH, 8, width of OPA/OPB (must match alu_design)
CMD_WIDTH, 4, width of CMD (must match alu_design)
DEPTH, 4, FIFO entries; power of 2, >=2
TAG_WIDTH, 4, width of the issue tag counter
ALU_LAT, 2, cycles from ALU_CE-high edge to ALU result valid for non-multiply ops

Ports:
CLK  input  1  clock, all logic on posedge
RST  input  1  reset, synchronous, active-low
IN_VALID  input  1  producer packet valid
IN_READY  output  1  queue can accept (not full)
IN_MODE  input  1  packet MODE
IN_CMD  input  CMD_WIDTH  packet CMD
IN_CIN  input  1  packet CIN
IN_INP_VALID  input  2  packet INP_VALID
IN_OPA  input  OPERAND_WIDTH  packet OPA
IN_OPB  input  OPERAND_WIDTH  packet OPB
FLUSH  input  1  synchronous queue clear
ALU_CE  output  1  to alu_design CE
ALU_MODE  output  1  to alu_design MODE
ALU_CMD  output  CMD_WIDTH  to alu_design CMD
ALU_CIN  output  1  to alu_design CIN
ALU_INP_VALID  output  2  to alu_design INP_VALID
ALU_OPA  output  OPERAND_WIDTH  to alu_design OPA
ALU_OPB  output  OPERAND_WIDTH  to alu_design OPB
RES_VLD  output  1  ALU result for RES_TAG valid this cycle
RES_TAG  output  TAG_WIDTH  tag of the result being reported
COUNT  output  clog2(DEPTH)+1  FIFO occupancy
DROP  output  1  packet discarded (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (RST==0 at posedge): FIFO empty, COUNT=0, IN_READY=0 during reset then 1. ALU_CE=0, ALU_MODE=0, ALU_CMD=0, ALU_CIN=0, ALU_INP_VALID=0, ALU_OPA=0, ALU_OPB=0. RES_VLD=0, RES_TAG=0, DROP=0, tag counter=0, FSM=RUN. In-flight result tracking is discarded.
- Push: IN_VALID && IN_READY at posedge. IN_READY = (COUNT<DEPTH), derived from registered COUNT only. Pointers wrap modulo DEPTH.
- No bypass: a packet pushed at edge N can issue no earlier than edge N+1. Issue selects only registered FIFO contents.
- Push and pop on the same edge: COUNT unchanged. At full, IN_READY=0, so no push occurs that cycle even if a pop happens.
- All ALU_* outputs are registered.
- FSM states:
  - RUN: at posedge, if FIFO non-empty, load the head into ALU_*, set ALU_CE=1, pop, increment tag. If the head is a multiply (MODE==1 and CMD==9 or 10), go to MUL_WAIT. If empty: ALU_CE=0, ALU_INP_VALID=0, operand/cmd outputs hold.
  - MUL_WAIT: exactly one cycle with ALU_CE=0, ALU_INP_VALID=0, other ALU_* held; no pop; then RUN.
- Result tracking: valid/tag shift pipe. A non-multiply issued with ALU_CE high at edge T gives RES_VLD=1, RES_TAG=tag at edge T+ALU_LAT for one cycle. A multiply gives the same at T+ALU_LAT+1. The MUL_WAIT bubble guarantees no two results share a cycle.
- Tag: the first issue after reset carries tag 0. Increments per issue, wraps 2^TAG_WIDTH-1 -> 0.
- FLUSH (RST high): at posedge, empties the FIFO (COUNT=0), forces FSM to RUN, sets ALU_CE=0 and ALU_INP_VALID=0. A push in the same cycle is dropped. Already-issued ops still report RES_VLD/RES_TAG. Tag counter is not reset.
- RST has priority over FLUSH, push and pop.

Optional Feature:
ALU_ISSUE_DROP_INVALID_EN
- Defined: a packet accepted with IN_INP_VALID==2'b00 is not enqueued. COUNT is unchanged, DROP pulses 1 for one cycle after the accepting edge, and no tag is consumed.
- Undefined: such packets are enqueued and issued normally; DROP is constant 0.

Test Plan:
- Reset: hold RST=0 for 3 cycles with IN_VALID=1 -> all outputs 0, COUNT=0; after release IN_READY=1.
- Back-to-back adds: 3 packets MODE=1, CMD=0, OPA=8'h05, OPB=8'h03, INP_VALID=2'b11 on consecutive cycles -> ALU_CE high 3 consecutive cycles starting the edge after the first push; RES_VLD with tags 0,1,2 at issue+2 each.
- Multiply bubble: push CMD=9 then CMD=0 (MODE=1) -> ALU_CE pattern 1,0,1. RES_VLD for tag 0 at issue+3 and tag 1 at issue+4; never two in one cycle.
- Full/backpressure: DEPTH=4, hold ALU-bound traffic after 4 pushes with the FIFO filled in one burst -> COUNT reaches 4 only if pushes outpace issue. With IN_VALID held, IN_READY=0 at COUNT=4, and pushes while not ready are not counted.
- FLUSH mid-stream: 3 entries queued, one multiply in flight, assert FLUSH -> COUNT=0 next cycle, ALU_CE=0, and the in-flight multiply's RES_VLD still appears on schedule.
- Tag wrap with ALU_ISSUE_DROP_INVALID_EN: issue 17 packets (TAG_WIDTH=4) -> 17th tag=0. Push one packet with INP_VALID=2'b00 -> DROP=1 for one cycle, COUNT unchanged, no tag consumed.
